// File: rtl/pwm_fade.sv
// Duty-cycle ramp generator feeding pwm8b value_in: walks value_out toward an
// accepted target by a fixed step every (rate+1) enabled clocks, then pulses done.
module pwm_fade #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_value,
  input  logic [DIV_W-1:0] rate,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] value_out,
  output logic             busy,
  output logic             done
);

  // Handshake: a target is taken on any rising edge where tgt_valid && tgt_ready.
  // tgt_ready is combinational and never depends on tgt_valid; a requester seeing
  // ready low must hold tgt_valid and its payload until the accept edge.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [WIDTH-1:0] tgt_q,   tgt_d;
  logic [DIV_W-1:0] rate_q,  rate_d;
  logic [WIDTH-1:0] step_q,  step_d;
  logic             done_q,  done_d;

  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_floor;
  logic [WIDTH-1:0] step_val;

  assign tgt_ready = (state_q == IDLE) && en;
  assign busy      = (state_q == RAMP);
  assign done      = done_q;
  assign value_out = value_q;

  // Both bounds are formed one bit wider so the clamp test cannot wrap.
  assign up_sum   = {1'b0, value_q} + {1'b0, step_q};
  assign dn_floor = {1'b0, tgt_q} + {1'b0, step_q};

  always_comb begin
    if (value_q < tgt_q) begin
      step_val = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[WIDTH-1:0];
    end else begin
      step_val = ({1'b0, value_q} < dn_floor) ? tgt_q : (value_q - step_q);
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    div_d   = div_q;
    tgt_d   = tgt_q;
    rate_d  = rate_q;
    step_d  = step_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          tgt_d  = tgt_value;
          rate_d = rate;
          step_d = (step == '0) ? WIDTH'(1) : step;
          div_d  = '0;
          if (tgt_value == value_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (en) begin
          if (div_q != rate_q) begin
            div_d = div_q + DIV_W'(1);
          end else begin
            div_d   = '0;
            value_d = step_val;
            if (step_val == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      value_q <= '0;
      div_q   <= '0;
      tgt_q   <= '0;
      rate_q  <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      div_q   <= div_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/pwm_fade.md
Name: pwm_fade

Overview:
- Duty-cycle ramp generator that sits directly upstream of pwm8b and drives its value_in.
- Accepts a target duty plus ramp parameters through a valid/ready handshake.
- Moves its 8-bit output toward the target by a fixed step, once every (rate+1) enabled clocks, without overshoot.
- Signals arrival at the target with a one-cycle done pulse. Used for LED fade/breathing effects.

Parameters:
- WIDTH, 8, width of duty value and step; must match pwm8b value_in width.
- DIV_W, 16, width of the rate divider and of the rate input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  global enable; low freezes the ramp and blocks new targets.
- tgt_valid  input  1  target request valid.
- tgt_ready  output  1  block can accept a target; combinational = (state==IDLE) && en.
- tgt_value  input  WIDTH  requested final duty.
- rate  input  DIV_W  extra clocks between steps; sampled on accept.
- step  input  WIDTH  increment per step; sampled on accept; 0 treated as 1.
- value_out  output  WIDTH  current duty, registered; connects to pwm8b value_in.
- busy  output  1  high while in RAMP.
- done  output  1  one-cycle pulse on reaching target.

Behaviour:
- Reset, sampled on clk rising edge with rst_n low: state=IDLE, value_out=0, div=0, busy=0, done=0, latched target/rate/step=0. tgt_ready follows en on the first cycle after reset.
- Reset mid-ramp aborts the ramp: value_out goes to 0 at that edge and no done pulse is produced.
- FSM has two states, IDLE and RAMP.
- Accept occurs on an edge with tgt_valid && tgt_ready.
  - Latch tgt_value, rate, and max(step,1).
  - Clear div to 0.
  - If tgt_value == value_out: stay in IDLE and set done=1 for the next cycle. value_out is unchanged.
  - Otherwise go to RAMP with busy=1 from the next cycle.
- RAMP, en=1:
  - If div != rate_l: div <= div+1.
  - Else: div <= 0 and value_out takes one step toward the target.
  - Up step: sum = {1'b0,value_out}+step_l, computed at WIDTH+1 bits. value_out <= (sum >= tgt) ? tgt : sum[WIDTH-1:0].
  - Down step: value_out <= (value_out < tgt+step_l, computed at WIDTH+1 bits) ? tgt : value_out-step_l.
  - Never wraps, never overshoots.
- Arrival: on the edge where value_out is written with tgt, state<=IDLE, busy<=0, done<=1 for exactly one cycle.
- Timing: first step lands (rate+1) enabled clocks after the accept edge, then one step every (rate+1) enabled clocks. rate=0 gives one step per clock.
- Total clocks accept→done = (rate+1) × ceil(|tgt−start|/step).
- en=0 in RAMP: div, value_out and state hold and tgt_ready=0. The ramp resumes exactly where it stopped when en returns high; it is not aborted.
- en=0 in IDLE: tgt_ready=0 and no accepts.
- done is not cleared by en=0: a pending done pulse still occurs.
- tgt_valid while busy is ignored (ready=0); the requester must hold it.
- Back-to-back: in the cycle done=1 the state is IDLE, so a new accept on that same edge is legal. A new ramp starts from the current value_out.
- value_out changes only on step or reset edges, so pwm8b sees a stable input between steps.

Test Plan:
- Reset then up ramp: rst_n low 2 clk, then high → value_out=0, busy=0, done=0, tgt_ready=1. Accept tgt=100, rate=9, step=10 → value_out 10,20,...,100, each step 10 clk apart. First step 10 clk after accept. done pulses once, 100 clk after accept; busy falls on the same edge.
- Saturating up and no overshoot: from 250, accept tgt=255, step=16, rate=0 → next clk value_out=255 (not 10), done pulses 1 clk after accept.
- Down ramp with clamp: from 200, accept tgt=5, step=50, rate=3 → 150,100,50,5 at 4-clk intervals. No wrap below 5. done after 16 clk.
- Equal target and step=0: value_out=100, accept tgt=100 → done 1 clk later, busy stays 0. Accept tgt=103 with step=0 → 101,102,103 with step 1.
- en freeze and blocked request: mid-ramp at value 40, drop en for 20 clk → value_out and div frozen, tgt_ready=0, and tgt_valid held high is not accepted. Restore en → remaining steps keep their original spacing. The held target is accepted on the done cycle.
- Reset mid-ramp: at value 60 during RAMP, pulse rst_n low 1 clk → value_out=0, busy=0, and no done pulse. tgt_ready=1 on the next cycle with en=1.
